alu_reservation_station: RTL and testbench

// - N-entry ALU reservation station feeding the ALU functional-unit wrapper.
// - Accepts dispatched ops and snoops CDB broadcasts to wake up pending operands.
// - Issues the oldest fully-ready op to the FU through a registered valid/ready stage.
// - It is the CDB consumer and the FU-issue producer: the opposite end of the FU's

---
 rtl/alu_reservation_station.sv | 169 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing age-ordered queue with CDB wakeup and a
// registered valid/ready issue stage toward the ALU functional unit.
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 8,
  parameter int TAG_W       = 6,
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [OPC_W-1:0]                   disp_opcode,
  input  logic [TAG_W-1:0]                   disp_dst_tag,
  input  logic                               disp_src1_rdy,
  input  logic [TAG_W-1:0]                   disp_src1_tag,
  input  logic [DATA_W-1:0]                  disp_src1_val,
  input  logic                               disp_src2_rdy,
  input  logic [TAG_W-1:0]                   disp_src2_tag,
  input  logic [DATA_W-1:0]                  disp_src2_val,
  input  logic                               cdb_valid,
  input  logic [TAG_W-1:0]                   cdb_tag,
  input  logic [DATA_W-1:0]                  cdb_data,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [OPC_W-1:0]                   issue_opcode,
  output logic [DATA_W-1:0]                  issue_src1,
  output logic [DATA_W-1:0]                  issue_src2,
  output logic [TAG_W-1:0]                   issue_dst_tag,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(NUM_ENTRIES+1);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef struct packed {
    logic              vld;
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  dst;
    logic              s1rdy;
    logic [TAG_W-1:0]  s1tag;
    logic [DATA_W-1:0] s1val;
    logic              s2rdy;
    logic [TAG_W-1:0]  s2tag;
    logic [DATA_W-1:0] s2val;
  } ent_t;

  ent_t              q_p0 [NUM_ENTRIES];
  logic [OCC_W-1:0]  occ_p0;
  ent_t              wk   [NUM_ENTRIES+1];
  ent_t              nx   [NUM_ENTRIES];
  ent_t              disp_ent;

  logic              vld_p1;
  logic [OPC_W-1:0]  opc_p1;
  logic [TAG_W-1:0]  dst_p1;
  logic [DATA_W-1:0] src1_p1;
  logic [DATA_W-1:0] src2_p1;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              load;
  logic              disp_fire;
  logic [OCC_W-1:0]  wr_idx;

  assign disp_ready = (occ_p0 != OCC_W'(NUM_ENTRIES));
  assign disp_fire  = disp_valid && disp_ready;

  // Stage p0: wakeup of stored entries from the CDB
  always_comb begin
    wk[NUM_ENTRIES] = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wk[i] = q_p0[i];
      if (cdb_valid && q_p0[i].vld && !q_p0[i].s1rdy && (q_p0[i].s1tag == cdb_tag)) begin
        wk[i].s1rdy = 1'b1;
        wk[i].s1val = cdb_data;
      end
      if (cdb_valid && q_p0[i].vld && !q_p0[i].s2rdy && (q_p0[i].s2tag == cdb_tag)) begin
        wk[i].s2rdy = 1'b1;
        wk[i].s2val = cdb_data;
      end
    end
  end

  // Incoming op, with same-cycle CDB bypass for not-yet-ready sources
  always_comb begin
    disp_ent       = '0;
    disp_ent.vld   = 1'b1;
    disp_ent.opc   = disp_opcode;
    disp_ent.dst   = disp_dst_tag;
    disp_ent.s1tag = disp_src1_tag;
    disp_ent.s2tag = disp_src2_tag;
    disp_ent.s1rdy = disp_src1_rdy || (cdb_valid && (disp_src1_tag == cdb_tag));
    disp_ent.s2rdy = disp_src2_rdy || (cdb_valid && (disp_src2_tag == cdb_tag));
    disp_ent.s1val = disp_src1_rdy ? disp_src1_val : cdb_data;
    disp_ent.s2val = disp_src2_rdy ? disp_src2_val : cdb_data;
  end

  // Oldest-first select looks only at registered ready bits
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (q_p0[i].vld && q_p0[i].s1rdy && q_p0[i].s2rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign load   = sel_found && (!vld_p1 || issue_ready);
  assign wr_idx = occ_p0 - {{(OCC_W-1){1'b0}}, load};

  // Collapse above the removed entry, then append the dispatched op at the tail
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (load && (IDX_W'(i) >= sel_idx)) begin
        nx[i] = wk[i+1];
      end else begin
        nx[i] = wk[i];
      end
      if (disp_fire && (OCC_W'(i) == wr_idx)) begin
        nx[i] = disp_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_p0 <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        q_p0[i].vld <= 1'b0;
      end
    end else begin
      occ_p0 <= occ_p0 + {{(OCC_W-1){1'b0}}, disp_fire} - {{(OCC_W-1){1'b0}}, load};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        q_p0[i] <= nx[i];
      end
    end
  end

  // Stage p1: issue register; payload held while the FU stalls
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p1  <= 1'b0;
      opc_p1  <= '0;
      dst_p1  <= '0;
      src1_p1 <= '0;
      src2_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      opc_p1  <= q_p0[sel_idx].opc;
      dst_p1  <= q_p0[sel_idx].dst;
      src1_p1 <= q_p0[sel_idx].s1val;
      src2_p1 <= q_p0[sel_idx].s2val;
    end else if (issue_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign issue_valid   = vld_p1;
  assign issue_opcode  = opc_p1;
  assign issue_dst_tag = dst_p1;
  assign issue_src1    = src1_p1;
  assign issue_src2    = src2_p1;
  assign occupancy     = occ_p0;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issues are queued at
// dispatch time and checked in order as the FU handshake completes.
module tb_alu_reservation_station;

  localparam int N      = 8;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 5;
  localparam int OCC_W  = $clog2(N+1);

  logic              clk = 1'b0;
  logic              reset, flush;
  logic              disp_valid, disp_ready;
  logic [OPC_W-1:0]  disp_opcode;
  logic [TAG_W-1:0]  disp_dst_tag;
  logic              disp_src1_rdy, disp_src2_rdy;
  logic [TAG_W-1:0]  disp_src1_tag, disp_src2_tag;
  logic [DATA_W-1:0] disp_src1_val, disp_src2_val;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_valid, issue_ready;
  logic [OPC_W-1:0]  issue_opcode;
  logic [DATA_W-1:0] issue_src1, issue_src2;
  logic [TAG_W-1:0]  issue_dst_tag;
  logic [OCC_W-1:0]  occupancy;

  always #5 clk = ~clk;

  alu_reservation_station #(
    .NUM_ENTRIES(N), .TAG_W(TAG_W), .DATA_W(DATA_W), .OPC_W(OPC_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_dst_tag(disp_dst_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_dst_tag(issue_dst_tag), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  dst;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_got, mon_want;
  int   tests_run = 0;
  int   fails     = 0;

  function automatic exp_t mk(input logic [OPC_W-1:0] opc, input logic [TAG_W-1:0] dst,
                              input logic [DATA_W-1:0] s1, input logic [DATA_W-1:0] s2);
    exp_t e;
    e.opc = opc; e.dst = dst; e.src1 = s1; e.src2 = s2;
    return e;
  endfunction

  // Scoreboard consumer: every accepted issue must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && !flush && issue_valid && issue_ready) begin
      mon_got = {issue_opcode, issue_dst_tag, issue_src1, issue_src2};
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got opc=%0d dst=%0d src1=%0h src2=%0h, required no issue",
                 issue_opcode, issue_dst_tag, issue_src1, issue_src2);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          fails++;
          $display("FAIL issue_payload: got opc=%0d dst=%0d src1=%0h src2=%0h, required opc=%0d dst=%0d src1=%0h src2=%0h",
                   mon_got.opc, mon_got.dst, mon_got.src1, mon_got.src2,
                   mon_want.opc, mon_want.dst, mon_want.src1, mon_want.src2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_dst_tag = '0;
    disp_src1_rdy = 1'b0; disp_src1_tag = '0; disp_src1_val = '0;
    disp_src2_rdy = 1'b0; disp_src2_tag = '0; disp_src2_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic drive_op(input logic [OPC_W-1:0] opc, input logic [TAG_W-1:0] dst,
                          input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                          input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
    disp_valid = 1'b1; disp_opcode = opc; disp_dst_tag = dst;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
  endtask

  task automatic test_reset();
    idle(); issue_ready = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL reset_issue_valid: got %b, required 0", issue_valid); end
    tests_run++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occupancy: got %0d, required 0", occupancy); end
    tests_run++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL reset_disp_ready: got %b, required 1", disp_ready); end
    tests_run++;
    if ({issue_opcode, issue_dst_tag, issue_src1, issue_src2} !== '0) begin
      fails++; $display("FAIL reset_payload: got opc=%0d dst=%0d src1=%0h src2=%0h, required all 0",
                        issue_opcode, issue_dst_tag, issue_src1, issue_src2);
    end
  endtask

  task automatic test_basic();
    issue_ready = 1'b1;
    tick(); idle(); drive_op(5'd3, 6'd1, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
    exp_q.push_back(mk(5'd3, 6'd1, 32'd5, 32'd7));
    tick(); idle();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL basic_t1_valid: got %b, required 0", issue_valid); end
    tests_run++; if (occupancy !== 4'd1) begin fails++; $display("FAIL basic_t1_occ: got %0d, required 1", occupancy); end
    tick();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL basic_t2_valid: got %b, required 1", issue_valid); end
    tests_run++; if (occupancy !== 4'd0) begin fails++; $display("FAIL basic_t2_occ: got %0d, required 0", occupancy); end
    tick();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL basic_t3_valid: got %b, required 0", issue_valid); end
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL basic_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_full();
    issue_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick(); idle();
      drive_op(OPC_W'(i), TAG_W'(10 + i), 1'b0, 6'd9, '0, 1'b1, '0, DATA_W'(100 + i));
    end
    tick(); idle(); drive_op(5'd31, 6'd63, 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
    @(negedge clk);
    tests_run++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL full_disp_ready: got %b, required 0", disp_ready); end
    tests_run++; if (occupancy !== 4'd8) begin fails++; $display("FAIL full_occ: got %0d, required 8", occupancy); end
    tick(); idle(); cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hAA;
    for (int i = 0; i < N; i++) exp_q.push_back(mk(OPC_W'(i), TAG_W'(10 + i), 32'hAA, DATA_W'(100 + i)));
    @(negedge clk);
    tests_run++; if (occupancy !== 4'd8) begin fails++; $display("FAIL full_ninth_rejected: got occ %0d, required 8", occupancy); end
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL full_no_early_issue: got %b, required 0", issue_valid); end
    tick(); idle();
    wait_drain(30);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    tick();
    @(negedge clk);
    tests_run++; if (occupancy !== 4'd0) begin fails++; $display("FAIL full_final_occ: got %0d, required 0", occupancy); end
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL full_final_valid: got %b, required 0", issue_valid); end
  endtask

  task automatic test_bypass();
    issue_ready = 1'b1;
    tick(); idle(); drive_op(5'd6, 6'd20, 1'b1, '0, 32'h11, 1'b0, 6'd4, '0);
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h55;
    exp_q.push_back(mk(5'd6, 6'd20, 32'h11, 32'h55));
    tick(); idle();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL bypass_t1_valid: got %b, required 0", issue_valid); end
    tick();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL bypass_t2_valid: got %b, required 1", issue_valid); end
    tick();
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL bypass_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wakeup_tag0();
    issue_ready = 1'b1;
    tick(); idle(); drive_op(5'd7, 6'd21, 1'b0, 6'd0, '0, 1'b0, 6'd0, '0);
    tick(); idle(); cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_data = 32'h77;
    exp_q.push_back(mk(5'd7, 6'd21, 32'h77, 32'h77));
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL tag0_c0_valid: got %b, required 0", issue_valid); end
    tick(); idle();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL tag0_c1_valid: got %b, required 0", issue_valid); end
    tick();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL tag0_c2_valid: got %b, required 1", issue_valid); end
    tick();
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL tag0_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_oldest();
    issue_ready = 1'b1;
    tick(); idle(); drive_op(5'd8, 6'd30, 1'b0, 6'd2, '0, 1'b1, '0, 32'h1234);
    tick(); idle(); drive_op(5'd9, 6'd31, 1'b1, '0, 32'hB1, 1'b1, '0, 32'hB2);
    exp_q.push_back(mk(5'd9, 6'd31, 32'hB1, 32'hB2));
    tick(); idle();
    wait_drain(10);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL oldest_young_first: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    tests_run++; if (occupancy !== 4'd1) begin fails++; $display("FAIL oldest_waiting_occ: got %0d, required 1", occupancy); end
    tick(); idle(); cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h22;
    exp_q.push_back(mk(5'd8, 6'd30, 32'h22, 32'h1234));
    tick(); idle();
    wait_drain(10);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL oldest_woken: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    tests_run++; if (occupancy !== 4'd0) begin fails++; $display("FAIL oldest_final_occ: got %0d, required 0", occupancy); end
  endtask

  task automatic test_stall();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      drive_op(OPC_W'(12 + i), TAG_W'(40 + i), 1'b1, '0, DATA_W'(32'h300 + i), 1'b1, '0, DATA_W'(32'h400 + i));
      exp_q.push_back(mk(OPC_W'(12 + i), TAG_W'(40 + i), DATA_W'(32'h300 + i), DATA_W'(32'h400 + i)));
    end
    for (int c = 0; c < 5; c++) begin
      tick(); idle();
      @(negedge clk);
      tests_run++;
      if (issue_valid !== 1'b1 || issue_opcode !== 5'd12 || issue_dst_tag !== 6'd40 ||
          issue_src1 !== 32'h300 || issue_src2 !== 32'h400) begin
        fails++; $display("FAIL stall_hold_%0d: got v=%b opc=%0d dst=%0d src1=%0h src2=%0h, required v=1 opc=12 dst=40 src1=300 src2=400",
                          c, issue_valid, issue_opcode, issue_dst_tag, issue_src1, issue_src2);
      end
      tests_run++; if (occupancy !== 4'd2) begin fails++; $display("FAIL stall_occ_%0d: got %0d, required 2", c, occupancy); end
    end
    tick(); issue_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL stall_drain_%0d: got valid %b, required 1", c, issue_valid); end
      tick();
    end
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL stall_drained_valid: got %b, required 0", issue_valid); end
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL stall_pending: got %0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_flush();
    exp_q.delete();
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); idle();
      drive_op(OPC_W'(20 + i), TAG_W'(50 + i), 1'b1, '0, DATA_W'(i), 1'b1, '0, DATA_W'(i));
    end
    tick(); idle();
    @(negedge clk);
    tests_run++; if (occupancy !== 4'd4) begin fails++; $display("FAIL flush_pre_occ: got %0d, required 4", occupancy); end
    tick(); idle(); flush = 1'b1; issue_ready = 1'b1;
    drive_op(5'd25, 6'd55, 1'b1, '0, 32'h9, 1'b1, '0, 32'h9);
    tick(); idle();
    @(negedge clk);
    tests_run++; if (occupancy !== 4'd0) begin fails++; $display("FAIL flush_occ: got %0d, required 0", occupancy); end
    tests_run++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b, required 0", issue_valid); end
    tests_run++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL flush_disp_ready: got %b, required 1", disp_ready); end
    tests_run++;
    if ({issue_opcode, issue_dst_tag, issue_src1, issue_src2} !== '0) begin
      fails++; $display("FAIL flush_payload: got opc=%0d dst=%0d src1=%0h src2=%0h, required all 0",
                        issue_opcode, issue_dst_tag, issue_src1, issue_src2);
    end
    tick(); tick();
    @(negedge clk);
    tests_run++; if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
      fails++; $display("FAIL flush_dropped: got valid %b occ %0d, required valid 0 occ 0", issue_valid, occupancy);
    end
    tick(); idle(); drive_op(5'd26, 6'd56, 1'b1, '0, 32'hC1, 1'b1, '0, 32'hC2);
    exp_q.push_back(mk(5'd26, 6'd56, 32'hC1, 32'hC2));
    tick(); idle();
    wait_drain(10);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL flush_recover: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; issue_ready = 1'b0; idle();
    test_reset();
    test_basic();
    test_full();
    test_bypass();
    test_wakeup_tag0();
    test_oldest();
    test_stall();
    test_flush();
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
